// File: rtl/csr_writeback_pipe.sv
// CSR write pipeline: carries EX writes through MEM and WB, commits them into the CSR bank at the end of WB.
// Optional commit counter port enabled by defining CSR_COMMIT_COUNT_EN.
module csr_writeback_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CSR    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            ex_csr_addr,
    input  logic [2:0]            ex_WB,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [4:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [4:0]            mem_rd_addr,
    output logic [4:0]            wb_rd_addr,
    output logic [2:0]            mem_WB,
    output logic [2:0]            wb_WB,
`ifdef CSR_COMMIT_COUNT_EN
    output logic [31:0]           commit_count,
`endif
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] wb_wdata
);

    typedef struct packed {
        logic [4:0]            idx;
        logic [2:0]            ctl;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    stage_t mem_q, mem_d;
    stage_t wb_q, wb_d;
    logic   commit_en;

    logic [DATA_WIDTH-1:0] bank_q [NUM_CSR];

    // NOTE: every variable written here gets its hold value first, so no path can infer a latch.
    always_comb begin
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!stall) begin
            wb_d  = mem_q;
            mem_d = flush ? stage_t'('0) : stage_t'{ex_csr_addr, ex_WB, ex_wdata};
        end
    end

    // Index 0 and out-of-range indices travel the pipe but never reach the bank.
    assign commit_en = !stall && wb_q.ctl[2] && (wb_q.idx != 5'd0)
                       && (int'(wb_q.idx) < NUM_CSR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // NOTE: the bank is reset as a register file (flops, not RAM) because a reset must clear every entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CSR; i++) begin
                bank_q[i] <= '0;
            end
        end else if (commit_en) begin
            bank_q[wb_q.idx] <= wb_q.data;
        end
    end

    assign rd_data = ((rd_addr != 5'd0) && (int'(rd_addr) < NUM_CSR)) ? bank_q[rd_addr] : '0;

`ifdef CSR_COMMIT_COUNT_EN
    logic [31:0] commit_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_count_q <= '0;
        end else if (commit_en) begin
            commit_count_q <= commit_count_q + 32'd1;
        end
    end

    assign commit_count = commit_count_q;
`endif

    assign mem_rd_addr = mem_q.idx;
    assign mem_WB      = mem_q.ctl;
    assign mem_wdata   = mem_q.data;
    assign wb_rd_addr  = wb_q.idx;
    assign wb_WB       = wb_q.ctl;
    assign wb_wdata    = wb_q.data;

endmodule

// File: tb/tb_csr_writeback_pipe.sv
// Self-checking bench for csr_writeback_pipe: directed scenarios plus randomized traffic against a queue-based model.
// Commit-counter checks are compiled in when CSR_COMMIT_COUNT_EN is defined.
module tb_csr_writeback_pipe;

    localparam int DW  = 32;
    localparam int NUM = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ex_csr_addr;
    logic [2:0]    ex_WB;
    logic [DW-1:0] ex_wdata;
    logic          stall;
    logic          flush;
    logic [4:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic [4:0]    mem_rd_addr, wb_rd_addr;
    logic [2:0]    mem_WB, wb_WB;
    logic [DW-1:0] mem_wdata, wb_wdata;
`ifdef CSR_COMMIT_COUNT_EN
    logic [31:0]   commit_count;
`endif

    csr_writeback_pipe #(.DATA_WIDTH(DW), .NUM_CSR(NUM)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_csr_addr (ex_csr_addr),
        .ex_WB       (ex_WB),
        .ex_wdata    (ex_wdata),
        .stall       (stall),
        .flush       (flush),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .mem_rd_addr (mem_rd_addr),
        .wb_rd_addr  (wb_rd_addr),
        .mem_WB      (mem_WB),
        .wb_WB       (wb_WB),
`ifdef CSR_COMMIT_COUNT_EN
        .commit_count(commit_count),
`endif
        .mem_wdata   (mem_wdata),
        .wb_wdata    (wb_wdata)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight writes as a two-slot queue (front = MEM, back = WB) and a plain bank array.
    typedef struct {
        logic [4:0]    idx;
        logic [2:0]    ctl;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          pipe[$];
    logic [DW-1:0] mbank [NUM];
    logic [31:0]   mcnt;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic ent_t bubble();
        ent_t e;
        e.idx = 5'd0; e.ctl = 3'b000; e.data = '0;
        return e;
    endfunction

    task automatic model_reset();
        pipe.delete();
        pipe.push_back(bubble());
        pipe.push_back(bubble());
        for (int i = 0; i < NUM; i++) mbank[i] = '0;
        mcnt = 32'd0;
    endtask

    task automatic model_edge(input logic [4:0] a, input logic [2:0] w, input logic [DW-1:0] d,
                              input logic st, input logic fl);
        ent_t old, nw;
        if (st) return;
        old = pipe.pop_back();
        if (old.ctl[2] && old.idx != 5'd0 && int'(old.idx) < NUM) begin
            mbank[old.idx] = old.data;
            mcnt = mcnt + 32'd1;
        end
        if (fl) nw = bubble();
        else begin
            nw.idx = a; nw.ctl = w; nw.data = d;
        end
        pipe.push_front(nw);
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [4:0] ra);
        if (ra == 5'd0 || int'(ra) >= NUM) return '0;
        return mbank[ra];
    endfunction

    // One clock: inputs driven at the falling edge, model advanced at the rising edge, outputs sampled 1ns later.
    task automatic apply(input logic [4:0] a, input logic [2:0] w, input logic [DW-1:0] d,
                         input logic st, input logic fl, input logic [4:0] ra);
        @(negedge clk);
        ex_csr_addr = a; ex_WB = w; ex_wdata = d;
        stall = st; flush = fl; rd_addr = ra;
        @(posedge clk);
        model_edge(a, w, d, st, fl);
        #1;
    endtask

    task automatic idle(input logic [4:0] ra);
        apply(5'd0, 3'b000, '0, 1'b0, 1'b0, ra);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_csr_addr = '0; ex_WB = '0; ex_wdata = '0;
        stall = 1'b0; flush = 1'b0; rd_addr = 5'd5;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({mem_rd_addr, wb_rd_addr, mem_WB, wb_WB} !== 16'h0) begin
            n_miss++;
            $display("FAIL reset_ctl: got mem_addr=%0d wb_addr=%0d mem_WB=%b wb_WB=%b expected all 0",
                     mem_rd_addr, wb_rd_addr, mem_WB, wb_WB);
        end
        n_vec++;
        if (mem_wdata !== 32'h0 || wb_wdata !== 32'h0 || rd_data !== 32'h0) begin
            n_miss++;
            $display("FAIL reset_data: got mem_wdata=%h wb_wdata=%h rd_data=%h expected 0",
                     mem_wdata, wb_wdata, rd_data);
        end
`ifdef CSR_COMMIT_COUNT_EN
        n_vec++;
        if (commit_count !== 32'd0) begin
            n_miss++;
            $display("FAIL reset_count: got %0d expected 0", commit_count);
        end
`endif
    endtask

    task automatic test_basic_write();
        logic [31:0] base;
        base = mcnt;
        apply(5'd5, 3'b100, 32'hDEADBEEF, 1'b0, 1'b0, 5'd5);
        n_vec++;
        if (mem_rd_addr !== 5'd5 || mem_WB !== 3'b100 || rd_data !== 32'h0) begin
            n_miss++;
            $display("FAIL basic_N: got mem_addr=%0d mem_WB=%b rd_data=%h expected 5 100 0",
                     mem_rd_addr, mem_WB, rd_data);
        end
        idle(5'd5);
        n_vec++;
        if (wb_wdata !== 32'hDEADBEEF || wb_rd_addr !== 5'd5 || rd_data !== 32'h0) begin
            n_miss++;
            $display("FAIL basic_N1: got wb_wdata=%h wb_addr=%0d rd_data=%h expected deadbeef 5 0",
                     wb_wdata, wb_rd_addr, rd_data);
        end
        idle(5'd5);
        n_vec++;
        if (rd_data !== 32'hDEADBEEF) begin
            n_miss++;
            $display("FAIL basic_N2: got rd_data=%h expected deadbeef", rd_data);
        end
`ifdef CSR_COMMIT_COUNT_EN
        n_vec++;
        if (commit_count !== base + 32'd1) begin
            n_miss++;
            $display("FAIL basic_count: got %0d expected %0d", commit_count, base + 32'd1);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] base;
        logic [31:0] old7;
        old7 = model_rd(5'd7);
        apply(5'd7, 3'b100, 32'h0000_7777, 1'b0, 1'b0, 5'd7);
        idle(5'd7);
        base = mcnt;
        for (int i = 0; i < 3; i++) begin
            apply(5'($urandom_range(1, 31)), 3'b111, $urandom, 1'b1, i[0], 5'd7);
            n_vec++;
            if (wb_rd_addr !== 5'd7 || wb_WB !== 3'b100 || wb_wdata !== 32'h0000_7777
                || mem_WB !== 3'b000 || rd_data !== old7) begin
                n_miss++;
                $display("FAIL stall_hold%0d: got wb=%0d/%b/%h mem_WB=%b rd=%h expected 7/100/00007777 000 %h",
                         i, wb_rd_addr, wb_WB, wb_wdata, mem_WB, rd_data, old7);
            end
        end
        idle(5'd7);
        n_vec++;
        if (rd_data !== 32'h0000_7777) begin
            n_miss++;
            $display("FAIL stall_release: got rd_data=%h expected 00007777", rd_data);
        end
        idle(5'd7);
`ifdef CSR_COMMIT_COUNT_EN
        n_vec++;
        if (commit_count !== base + 32'd1) begin
            n_miss++;
            $display("FAIL stall_count: got %0d expected %0d", commit_count, base + 32'd1);
        end
`endif
    endtask

    task automatic test_flush();
        logic [31:0] old9;
        old9 = model_rd(5'd9);
        apply(5'd9, 3'b100, 32'h0000_0099, 1'b0, 1'b1, 5'd9);
        n_vec++;
        if (mem_WB !== 3'b000 || mem_rd_addr !== 5'd0 || mem_wdata !== 32'h0) begin
            n_miss++;
            $display("FAIL flush_bubble: got mem=%0d/%b/%h expected 0/000/0", mem_rd_addr, mem_WB, mem_wdata);
        end
        idle(5'd9);
        idle(5'd9);
        n_vec++;
        if (rd_data !== old9) begin
            n_miss++;
            $display("FAIL flush_bank: got rd_data=%h expected %h", rd_data, old9);
        end
        apply(5'd9, 3'b100, 32'h0000_009A, 1'b0, 1'b0, 5'd9);
        apply(5'd9, 3'b100, 32'h0000_009B, 1'b1, 1'b1, 5'd9);
        n_vec++;
        if (mem_rd_addr !== 5'd9 || mem_WB !== 3'b100 || mem_wdata !== 32'h0000_009A) begin
            n_miss++;
            $display("FAIL flush_stall: got mem=%0d/%b/%h expected 9/100/0000009a", mem_rd_addr, mem_WB, mem_wdata);
        end
        idle(5'd9);
        idle(5'd9);
        n_vec++;
        if (rd_data !== 32'h0000_009A) begin
            n_miss++;
            $display("FAIL flush_stall_commit: got rd_data=%h expected 0000009a", rd_data);
        end
    endtask

    task automatic test_index0_order();
        logic [31:0] base;
        base = mcnt;
        apply(5'd0, 3'b100, 32'h1, 1'b0, 1'b0, 5'd0);
        n_vec++;
        if (mem_WB !== 3'b100 || mem_rd_addr !== 5'd0) begin
            n_miss++;
            $display("FAIL idx0_mem: got mem_addr=%0d mem_WB=%b expected 0 100", mem_rd_addr, mem_WB);
        end
        idle(5'd0);
        idle(5'd0);
        n_vec++;
        if (rd_data !== 32'h0) begin
            n_miss++;
            $display("FAIL idx0_read: got rd_data=%h expected 0", rd_data);
        end
`ifdef CSR_COMMIT_COUNT_EN
        n_vec++;
        if (commit_count !== base) begin
            n_miss++;
            $display("FAIL idx0_count: got %0d expected %0d", commit_count, base);
        end
`endif
        apply(5'd3, 3'b100, 32'hA, 1'b0, 1'b0, 5'd3);
        apply(5'd3, 3'b101, 32'hB, 1'b0, 1'b0, 5'd3);
        idle(5'd3);
        n_vec++;
        if (rd_data !== 32'hA) begin
            n_miss++;
            $display("FAIL order_first: got rd_data=%h expected a", rd_data);
        end
        idle(5'd3);
        n_vec++;
        if (rd_data !== 32'hB) begin
            n_miss++;
            $display("FAIL order_last: got rd_data=%h expected b", rd_data);
        end
`ifdef CSR_COMMIT_COUNT_EN
        n_vec++;
        if (commit_count !== base + 32'd2) begin
            n_miss++;
            $display("FAIL order_count: got %0d expected %0d", commit_count, base + 32'd2);
        end
`endif
    endtask

    task automatic test_random();
        ent_t em, ew;
        for (int i = 0; i < 400; i++) begin
            apply(5'($urandom), 3'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 0) ? 5'($urandom_range(1, 6)) : 5'($urandom));
            em = pipe[0];
            ew = pipe[1];
            n_vec++;
            if (mem_rd_addr !== em.idx || mem_WB !== em.ctl || mem_wdata !== em.data) begin
                n_miss++;
                $display("FAIL rand_mem@%0d: got %0d/%b/%h expected %0d/%b/%h",
                         i, mem_rd_addr, mem_WB, mem_wdata, em.idx, em.ctl, em.data);
            end
            n_vec++;
            if (wb_rd_addr !== ew.idx || wb_WB !== ew.ctl || wb_wdata !== ew.data) begin
                n_miss++;
                $display("FAIL rand_wb@%0d: got %0d/%b/%h expected %0d/%b/%h",
                         i, wb_rd_addr, wb_WB, wb_wdata, ew.idx, ew.ctl, ew.data);
            end
            n_vec++;
            if (rd_data !== model_rd(rd_addr)) begin
                n_miss++;
                $display("FAIL rand_rd@%0d: addr=%0d got %h expected %h", i, rd_addr, rd_data, model_rd(rd_addr));
            end
`ifdef CSR_COMMIT_COUNT_EN
            n_vec++;
            if (commit_count !== mcnt) begin
                n_miss++;
                $display("FAIL rand_count@%0d: got %0d expected %0d", i, commit_count, mcnt);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        apply(5'd12, 3'b100, 32'h00C0FFEE, 1'b0, 1'b0, 5'd5);
        idle(5'd5);
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (wb_WB !== 3'b000 || wb_rd_addr !== 5'd0 || mem_WB !== 3'b000 || rd_data !== 32'h0) begin
            n_miss++;
            $display("FAIL midrst_clear: got wb=%0d/%b mem_WB=%b rd5=%h expected 0/000 000 0",
                     wb_rd_addr, wb_WB, mem_WB, rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(5'd12);
        idle(5'd12);
        n_vec++;
        if (rd_data !== 32'h0) begin
            n_miss++;
            $display("FAIL midrst_lost: got rd_data=%h expected 0", rd_data);
        end
    endtask

`ifdef CSR_COMMIT_COUNT_EN
    task automatic test_wrap();
        @(negedge clk);
        force dut.commit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_count_q;
        mcnt = 32'hFFFF_FFFF;
        apply(5'd4, 3'b100, 32'h4444, 1'b0, 1'b0, 5'd4);
        idle(5'd4);
        idle(5'd4);
        n_vec++;
        if (commit_count !== 32'd0 || rd_data !== 32'h4444) begin
            n_miss++;
            $display("FAIL wrap: got count=%h rd_data=%h expected 0 4444", commit_count, rd_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_write();
        test_stall();
        test_flush();
        test_index0_order();
        test_random();
        test_reset_mid();
`ifdef CSR_COMMIT_COUNT_EN
        test_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
